dds_sincos_lut: RTL and testbench
=================================

Name: dds_sincos_lut

Overview:
- Phase-to-amplitude stage of the DDS. Sits directly downstream of the phase accumulator and consumes its truncated phase word.
- Produces quadrature sine/cosine samples for the lock-in mixers.
- Stores a quarter-wave ROM and uses quadrant symmetry to build full sin/cos.
- Supports a programmable phase offset, so the reference can be rotated relative to the accumulator.

Parameters:
phase_bits, 32, width of incoming phase word and offset
lut_addr_bits, 10, log2 of quarter-wave ROM depth (N = 2^lut_addr_bits entries)
amp_bits, 16, signed output sample width
out_bus_size, 16, output bus width (multiple of 8, >= amp_bits; upper bits sign-extended)

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous active-high reset
phase_in  in  phase_bits  unsigned phase, full circle = 2^phase_bits
phase_valid_i  in  1  phase_in valid this cycle
phase_offset  in  phase_bits  offset value to load
offset_load  in  1  load phase_offset into internal offset register
sin_out  out  out_bus_size  signed sine sample
cos_out  out  out_bus_size  signed cosine sample
valid_o  out  1  sin_out/cos_out updated this cycle

Behaviour:
- Clock and reset: one clock `clk`. Synchronous, active-high reset `rst`, sampled only on rising clk.
- Reset state:
  - offset register = 0.
  - All pipeline valid bits = 0.
  - sin_out = 0, cos_out = 0, valid_o = 0.
- Offset register:
  - Loads phase_offset on any cycle with offset_load=1, regardless of phase_valid_i.
  - The new value applies to samples entering S1 on the following cycle or later.
  - If offset_load and phase_valid_i are high in the same cycle, that sample uses the old offset.
- Pipeline: fixed latency 4. A sample with phase_valid_i=1 at edge t gives valid_o=1 after edge t+4.
  - S1: p = (phase_in + offset) mod 2^phase_bits, registered. Wrap-around is silent.
  - S2: quadrant q = p[phase_bits-1 : phase_bits-2]; idx = next lut_addr_bits bits; lower bits truncated (no rounding, no dither). Register q, idx, and ridx = N-1-idx.
  - S3: synchronous dual read of ROM[idx] and ROM[ridx]; register q alongside.
  - S4: apply symmetry, then register outputs:
    - q=0: sin = +ROM[idx], cos = +ROM[ridx]
    - q=1: sin = +ROM[ridx], cos = -ROM[idx]
    - q=2: sin = -ROM[idx], cos = -ROM[ridx]
    - q=3: sin = -ROM[ridx], cos = +ROM[idx]
- ROM contents:
  - A = 2^(amp_bits-1)-1.
  - ROM[k] = round(A * sin((pi/2) * (k+0.5)/N)), k = 0..N-1.
  - Entries are non-negative, max A, so negation never overflows.
  - The half-step offset makes all four quadrants exactly symmetric; no special case at quadrant edges.
- Valid handling:
  - Valid bits shift through S1–S4 every cycle. No backpressure; accepts one sample per cycle.
  - Output registers update only when the S4 valid bit = 1; otherwise they hold the last value.
  - valid_o is a 1-cycle strobe per sample. Back-to-back inputs give back-to-back outputs.
- Reset mid-operation: all in-flight samples are discarded. valid_o = 0 and outputs = 0 from the cycle after reset is sampled. No stale sample emerges after reset deasserts.
- Output sign extension: bits above amp_bits in sin_out/cos_out replicate the sign bit.

Test Plan:
- Quadrant walk (defaults: N=1024, A=32767, offset=0). Expected results, 4 cycles after each input:
  - phase_in=0x00000000 → sin=25, cos=32767
  - phase_in=0x40000000 → sin=32767, cos=-25
  - phase_in=0x80000000 → sin=-25, cos=-32767
  - phase_in=0xC0000000 → sin=-32767, cos=25
- Offset: offset_load=1 with phase_offset=0x40000000, next cycle phase_in=0 valid → sin=32767, cos=-25. Same-cycle load plus valid phase_in=0 → sin=25, cos=32767 (old offset).
- Wrap: offset=1, phase_in=0xFFFFFFFF → p=0 → sin=25, cos=32767. No error flag or glitch.
- Latency/strobe: single phase_valid_i pulse at cycle 10 → valid_o high only at cycle 14; outputs hold value through cycles 15–20 with valid_o=0.
- Streaming: 2^12 consecutive valid inputs stepping 0x00100000 → 4096 consecutive valid_o strobes. Check:
  - every output matches a golden model to the bit;
  - sin²+cos² stays within ±0.1% of A².
- Reset mid-stream: assert rst for 1 cycle while 3 samples are in flight → valid_o=0 and outputs=0 next cycle; no valid_o until 4 cycles after the first post-reset input.

Source files
------------

// File: rtl/dds_sincos_lut.sv
// Phase-to-amplitude stage: quarter-wave sine ROM plus quadrant symmetry
// turns a phase word into quadrature sin/cos samples with a fixed 4-cycle latency.
module dds_sincos_lut #(
  parameter int phase_bits    = 32,
  parameter int lut_addr_bits = 10,
  parameter int amp_bits      = 16,
  parameter int out_bus_size  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [phase_bits-1:0]   phase_in,
  input  logic                    phase_valid_i,
  input  logic [phase_bits-1:0]   phase_offset,
  input  logic                    offset_load,
  output logic [out_bus_size-1:0] sin_out,
  output logic [out_bus_size-1:0] cos_out,
  output logic                    valid_o
);

  localparam int  lut_n   = 1 << lut_addr_bits;
  localparam int  trunc_w = phase_bits - lut_addr_bits - 2;
  localparam real pi      = 3.14159265358979323846;
  localparam real amp     = real'((1 << (amp_bits - 1)) - 1);

  logic [amp_bits-1:0] rom [lut_n];

  // Half-step sample points make the table mirror exactly across quadrant edges.
  for (genvar k = 0; k < lut_n; k++) begin : g_rom
    localparam real ang = (pi / 2.0) * (real'(k) + 0.5) / real'(lut_n);
    localparam int  val = $rtoi(amp * $sin(ang) + 0.5);
    assign rom[k] = amp_bits'(val);
  end

  logic [phase_bits-1:0]    offset_reg;
  logic [phase_bits-1:0]    p_s1;
  logic                     v1, v2, v3, v4;
  logic [1:0]               q_s2, q_s3;
  logic [lut_addr_bits-1:0] idx_s2, ridx_s2;
  logic [lut_addr_bits-1:0] idx_next;
  logic [amp_bits-1:0]      rom_a, rom_b;
  logic signed [amp_bits-1:0] sin_comb, cos_comb;
  logic signed [amp_bits-1:0] sin_s4, cos_s4;
  logic                     unused_trunc;

  assign idx_next     = p_s1[phase_bits-3 -: lut_addr_bits];
  assign unused_trunc = &{1'b0, p_s1[trunc_w-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_reg <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      v4         <= 1'b0;
    end else begin
      if (offset_load) offset_reg <= phase_offset;
      v1 <= phase_valid_i;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

  // Datapath registers carry no reset; the valid bits decide what reaches the outputs.
  always_ff @(posedge clk) begin
    p_s1    <= phase_in + offset_reg;
    q_s2    <= p_s1[phase_bits-1 -: 2];
    idx_s2  <= idx_next;
    ridx_s2 <= lut_addr_bits'(lut_n - 1) - idx_next;
    rom_a   <= rom[idx_s2];
    rom_b   <= rom[ridx_s2];
    q_s3    <= q_s2;
    sin_s4  <= sin_comb;
    cos_s4  <= cos_comb;
  end

  // ROM entries never exceed 2^(amp_bits-1)-1, so signed negation cannot overflow.
  always_comb begin
    sin_comb = '0;
    cos_comb = '0;
    unique case (q_s3)
      2'd0: begin
        sin_comb = $signed(rom_a);
        cos_comb = $signed(rom_b);
      end
      2'd1: begin
        sin_comb = $signed(rom_b);
        cos_comb = -$signed(rom_a);
      end
      2'd2: begin
        sin_comb = -$signed(rom_a);
        cos_comb = -$signed(rom_b);
      end
      2'd3: begin
        sin_comb = -$signed(rom_b);
        cos_comb = $signed(rom_a);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sin_out <= '0;
      cos_out <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= v4;
      if (v4) begin
        sin_out <= out_bus_size'(sin_s4);
        cos_out <= out_bus_size'(cos_s4);
      end
    end
  end

endmodule

// File: tb/tb_dds_sincos_lut.sv
// Self-checking bench for dds_sincos_lut: trig-based reference model checked every
// cycle, plus directed vectors with hand-computed sin/cos values.
module tb_dds_sincos_lut;

  localparam real PI   = 3.14159265358979323846;
  localparam real AMP  = 32767.0;
  localparam int  A_SQ = 32767 * 32767;
  localparam int  TOL  = A_SQ / 1000;

  logic        clk;
  logic        rst;
  logic [31:0] phase_in;
  logic        phase_valid_i;
  logic [31:0] phase_offset;
  logic        offset_load;
  logic [15:0] sin_out;
  logic [15:0] cos_out;
  logic        valid_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_s [int];
  int exp_c [int];
  int held_s = 0;
  int held_c = 0;
  logic [31:0] mdl_offset = '0;

  dds_sincos_lut dut (
    .clk          (clk),
    .rst          (rst),
    .phase_in     (phase_in),
    .phase_valid_i(phase_valid_i),
    .phase_offset (phase_offset),
    .offset_load  (offset_load),
    .sin_out      (sin_out),
    .cos_out      (cos_out),
    .valid_o      (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int round_sym(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Ideal quadrature sample at the centre of the 4096-step phase bin the word falls in.
  function automatic void model(input logic [31:0] p, output int s, output int c);
    logic [11:0] bin;
    real th;
    bin = p[31:20];
    th  = 2.0 * PI * (real'(bin) + 0.5) / 4096.0;
    s   = round_sym(AMP * $sin(th));
    c   = round_sym(AMP * $cos(th));
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  always @(posedge clk) begin
    int s, c;
    logic [31:0] p;
    cyc++;
    if (rst) begin
      exp_s.delete();
      exp_c.delete();
      mdl_offset = '0;
      held_s = 0;
      held_c = 0;
    end else begin
      if (phase_valid_i) begin
        p = phase_in + mdl_offset;
        model(p, s, c);
        exp_s[cyc + 4] = s;
        exp_c[cyc + 4] = c;
      end
      if (offset_load) mdl_offset = phase_offset;
      if (exp_s.exists(cyc)) begin
        held_s = exp_s[cyc];
        held_c = exp_c[cyc];
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (cyc > 0) begin
      check("valid_o", int'(valid_o), exp_s.exists(cyc) ? 1 : 0);
      check("sin_out", int'($signed(sin_out)), held_s);
      check("cos_out", int'($signed(cos_out)), held_c);
      if (exp_s.exists(cyc)) begin
        e = int'($signed(sin_out)) * int'($signed(sin_out))
          + int'($signed(cos_out)) * int'($signed(cos_out));
        n_checks++;
        if (e >= A_SQ - TOL && e <= A_SQ + TOL) n_pass++;
        else $display("[TB] FAIL energy at cycle %0d: got %0d, expected %0d +/- %0d", cyc, e, A_SQ, TOL);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ph,
                               input logic ld, input logic [31:0] off);
    @(negedge clk);
    phase_valid_i = v;
    phase_in      = ph;
    offset_load   = ld;
    phase_offset  = off;
  endtask

  task automatic checkOutput(input string name, input int s, input int c);
    check({name, "_valid"}, int'(valid_o), 1);
    check({name, "_sin"}, int'($signed(sin_out)), s);
    check({name, "_cos"}, int'($signed(cos_out)), c);
  endtask

  task automatic runVector(input string name, input logic [31:0] ph, input logic ld,
                           input logic [31:0] off, input int s, input int c);
    applyStimulus(1'b1, ph, ld, off);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    #1 checkOutput(name, s, c);
  endtask

  initial begin
    rst           = 1'b1;
    phase_valid_i = 1'b0;
    phase_in      = '0;
    offset_load   = 1'b0;
    phase_offset  = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_valid", int'(valid_o), 0);
    check("reset_sin", int'($signed(sin_out)), 0);
    check("reset_cos", int'($signed(cos_out)), 0);
    rst = 1'b0;

    runVector("q0", 32'h0000_0000, 1'b0, '0, 25, 32767);
    runVector("q1", 32'h4000_0000, 1'b0, '0, 32767, -25);
    runVector("q2", 32'h8000_0000, 1'b0, '0, -25, -32767);
    runVector("q3", 32'hC000_0000, 1'b0, '0, -32767, 25);

    applyStimulus(1'b0, '0, 1'b1, 32'h4000_0000);
    runVector("offset_new", 32'h0, 1'b0, '0, 32767, -25);
    runVector("offset_same_cycle", 32'h0, 1'b1, 32'h0, 32767, -25);
    runVector("offset_cleared", 32'h0, 1'b0, '0, 25, 32767);

    applyStimulus(1'b0, '0, 1'b1, 32'h1);
    runVector("wrap", 32'hFFFF_FFFF, 1'b0, '0, 25, 32767);
    applyStimulus(1'b0, '0, 1'b1, 32'h0);

    runVector("strobe", 32'h8000_0000, 1'b0, '0, -25, -32767);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", int'(valid_o), 0);
      check("hold_sin", int'($signed(sin_out)), -25);
      check("hold_cos", int'($signed(cos_out)), -32767);
    end

    for (int i = 0; i < 4096; i++) applyStimulus(1'b1, 32'(i) << 20, 1'b0, '0);
    repeat (6) applyStimulus(1'b0, '0, 1'b0, '0);

    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 32'(i) << 28, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    phase_valid_i = 1'b1;
    phase_in = 32'h4000_0000;
    @(negedge clk);
    rst = 1'b0;
    phase_valid_i = 1'b0;
    #1;
    check("midreset_valid", int'(valid_o), 0);
    check("midreset_sin", int'($signed(sin_out)), 0);
    check("midreset_cos", int'($signed(cos_out)), 0);
    repeat (5) applyStimulus(1'b0, '0, 1'b0, '0);
    runVector("post_reset", 32'h4000_0000, 1'b0, '0, 32767, -25);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
